// File: rtl/mux_unstriping.sv
// Merges two skewed 32-bit lane streams back into one stream, lane 0 first then alternating.
// Latency: a word strobed on edge k appears on data_out after edge k+1 at the earliest.
// Backpressure: none on the output; a word strobed into a full lane FIFO is dropped and flagged sticky.

module mux_unstriping_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] head_dat,
  output logic [PTR_W:0]   fill,
  output logic             drop
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (fill == '0);
  assign full     = (fill == FULL_CNT);
  assign do_pop   = pop_rdy && !empty;
  // A full FIFO still accepts a word when its head leaves on the same edge.
  assign do_push  = push_vld && (!full || do_pop);
  assign drop     = push_vld && full && !do_pop;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk_2f) begin
    if (!reset && do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   fill <= fill + (PTR_W+1)'(1);
        2'b01:   fill <= fill - (PTR_W+1)'(1);
        default: fill <= fill;
      endcase
    end
  end
endmodule

module mux_unstriping #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic [WIDTH-1:0] lane_0,
  input  logic             valid_in0,
  input  logic [WIDTH-1:0] lane_1,
  input  logic             valid_in1,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             overflow,
  output logic [PTR_W:0]   fill0,
  output logic [PTR_W:0]   fill1
);
  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } sel_t;

  sel_t             sel;
  sel_t             sel_nxt;
  logic             pop0;
  logic             pop1;
  logic             pop_vld;
  logic [WIDTH-1:0] pop_dat;
  logic [WIDTH-1:0] head0_dat;
  logic [WIDTH-1:0] head1_dat;
  logic             drop0;
  logic             drop1;

  mux_unstriping_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo0 (
    .clk_2f   (clk_2f),
    .reset    (reset),
    .push_vld (valid_in0),
    .push_dat (lane_0),
    .pop_rdy  (pop0),
    .head_dat (head0_dat),
    .fill     (fill0),
    .drop     (drop0)
  );

  mux_unstriping_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo1 (
    .clk_2f   (clk_2f),
    .reset    (reset),
    .push_vld (valid_in1),
    .push_dat (lane_1),
    .pop_rdy  (pop1),
    .head_dat (head1_dat),
    .fill     (fill1),
    .drop     (drop1)
  );

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      sel <= LANE0;
    end else begin
      sel <= sel_nxt;
    end
  end

  // Never skip an empty lane: stalling on it is what keeps the original order.
  always_comb begin
    sel_nxt = sel;
    pop0    = 1'b0;
    pop1    = 1'b0;
    pop_vld = 1'b0;
    pop_dat = head0_dat;
    case (sel)
      LANE0: begin
        if (fill0 != '0) begin
          pop0    = 1'b1;
          pop_vld = 1'b1;
          pop_dat = head0_dat;
          sel_nxt = LANE1;
        end
      end
      LANE1: begin
        if (fill1 != '0) begin
          pop1    = 1'b1;
          pop_vld = 1'b1;
          pop_dat = head1_dat;
          sel_nxt = LANE0;
        end
      end
      default: sel_nxt = LANE0;
    endcase
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      valid_out <= pop_vld;
      if (pop_vld) begin
        data_out <= pop_dat;
      end
      overflow <= overflow | drop0 | drop1;
    end
  end
endmodule

// File: tb/tb_mux_unstriping.sv
// Directed bench for mux_unstriping: expected output words are queued per test and a
// monitor branch compares them whenever valid_out is high; status outputs are checked directly.

module tb_mux_unstriping;
  logic        clk_2f = 1'b0;
  logic        reset;
  logic [31:0] lane_0;
  logic        valid_in0;
  logic [31:0] lane_1;
  logic        valid_in1;
  logic [31:0] data_out;
  logic        valid_out;
  logic        overflow;
  logic [2:0]  fill0;
  logic [2:0]  fill1;

  int          checks = 0;
  int          errors = 0;
  int          vcount;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;

  mux_unstriping #(.WIDTH(32), .DEPTH(4), .PTR_W(2)) dut (
    .clk_2f    (clk_2f),
    .reset     (reset),
    .lane_0    (lane_0),
    .valid_in0 (valid_in0),
    .lane_1    (lane_1),
    .valid_in1 (valid_in1),
    .data_out  (data_out),
    .valid_out (valid_out),
    .overflow  (overflow),
    .fill0     (fill0),
    .fill1     (fill1)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one edge's worth of inputs (called at a negedge), return at the next negedge.
  task automatic cyc(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
    valid_in0 = v0;
    lane_0    = d0;
    valid_in1 = v1;
    lane_1    = d1;
    @(negedge clk_2f);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
    lane_0    = '0;
    lane_1    = '0;
    @(negedge clk_2f);
    reset = 1'b0;

    fork
      forever begin
        @(negedge clk_2f);
        if (valid_out === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word actual=%h required=none", data_out);
          end else begin
            exp_w = exp_q.pop_front();
            chk("data_out_order", data_out, exp_w);
          end
        end
      end
    join_none

    // Reset state
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_valid_out", {31'h0, valid_out}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    chk("rst_fill0", {29'h0, fill0}, 32'h0);
    chk("rst_fill1", {29'h0, fill1}, 32'h0);

    // Basic pair
    exp_q.push_back(32'hAAAA0001);
    exp_q.push_back(32'hBBBB0001);
    cyc(1'b1, 32'hAAAA0001, 1'b0, 32'h0);
    chk("pair_fill0_e1", {29'h0, fill0}, 32'h1);
    chk("pair_valid_e1", {31'h0, valid_out}, 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 32'hBBBB0001);
    chk("pair_valid_e2", {31'h0, valid_out}, 32'h1);
    idle(1);
    chk("pair_valid_e3", {31'h0, valid_out}, 32'h1);
    idle(1);
    chk("pair_valid_e4", {31'h0, valid_out}, 32'h0);

    // Skew: lane 1 runs three cycles ahead
    exp_q.push_back(32'hA1);
    exp_q.push_back(32'hB1);
    exp_q.push_back(32'hA2);
    exp_q.push_back(32'hB2);
    cyc(1'b0, 32'h0, 1'b1, 32'hB1);
    cyc(1'b0, 32'h0, 1'b1, 32'hB2);
    chk("skew_fill1_peak", {29'h0, fill1}, 32'h2);
    idle(1);
    cyc(1'b1, 32'hA1, 1'b0, 32'h0);
    chk("skew_stall_valid", {31'h0, valid_out}, 32'h0);
    chk("skew_fill1_hold", {29'h0, fill1}, 32'h2);
    cyc(1'b1, 32'hA2, 1'b0, 32'h0);
    chk("skew_valid_a1", {31'h0, valid_out}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("skew_valid_run", {31'h0, valid_out}, 32'h1);
    end
    idle(1);
    chk("skew_valid_end", {31'h0, valid_out}, 32'h0);

    // Overflow on lane 1, then drain with lane 0
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 32'hC0 + 32'(i));
      if (i == 4) chk("ovf_fill1_full", {29'h0, fill1}, 32'h4);
      if (i == 4) chk("ovf_not_yet", {31'h0, overflow}, 32'h0);
    end
    chk("ovf_set", {31'h0, overflow}, 32'h1);
    chk("ovf_fill1_after_drop", {29'h0, fill1}, 32'h4);
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(32'hD0 + 32'(i));
      exp_q.push_back(32'hC0 + 32'(i));
    end
    for (int i = 1; i <= 4; i++) cyc(1'b1, 32'hD0 + 32'(i), 1'b0, 32'h0);
    idle(6);
    chk("ovf_sticky", {31'h0, overflow}, 32'h1);
    chk("ovf_drained_fill1", {29'h0, fill1}, 32'h0);
    chk("ovf_queue_empty", 32'(exp_q.size()), 32'h0);

    // Full lane 0 with a pop on the same edge
    do_reset();
    chk("rst2_overflow", {31'h0, overflow}, 32'h0);
    exp_q.push_back(32'hE1);
    exp_q.push_back(32'hF1);
    exp_q.push_back(32'hE2);
    exp_q.push_back(32'h61);
    exp_q.push_back(32'hE3);
    exp_q.push_back(32'h62);
    exp_q.push_back(32'hE4);
    exp_q.push_back(32'h63);
    exp_q.push_back(32'hE5);
    exp_q.push_back(32'h64);
    exp_q.push_back(32'hA5);
    for (int i = 1; i <= 5; i++) cyc(1'b1, 32'hE0 + 32'(i), 1'b0, 32'h0);
    chk("full_fill0", {29'h0, fill0}, 32'h4);
    cyc(1'b0, 32'h0, 1'b1, 32'hF1);
    idle(1);
    chk("full_fill0_sel0", {29'h0, fill0}, 32'h4);
    cyc(1'b1, 32'hA5, 1'b0, 32'h0);
    chk("full_pop_fill0", {29'h0, fill0}, 32'h4);
    chk("full_pop_overflow", {31'h0, overflow}, 32'h0);
    for (int i = 1; i <= 4; i++) cyc(1'b0, 32'h0, 1'b1, 32'h60 + 32'(i));
    idle(6);
    chk("full_queue_empty", 32'(exp_q.size()), 32'h0);

    // Reset mid-stream (sel currently on lane 1, lane 1 empty)
    cyc(1'b1, 32'h71, 1'b0, 32'h0);
    cyc(1'b1, 32'h72, 1'b1, 32'h81);
    chk("mid_fill0", {29'h0, fill0}, 32'h2);
    chk("mid_fill1", {29'h0, fill1}, 32'h1);
    reset = 1'b1;
    cyc(1'b1, 32'h73, 1'b1, 32'h82);
    reset = 1'b0;
    chk("mid_rst_data", data_out, 32'h0);
    chk("mid_rst_valid", {31'h0, valid_out}, 32'h0);
    chk("mid_rst_fill0", {29'h0, fill0}, 32'h0);
    chk("mid_rst_fill1", {29'h0, fill1}, 32'h0);
    exp_q.push_back(32'h11);
    exp_q.push_back(32'h22);
    cyc(1'b1, 32'h11, 1'b1, 32'h22);
    idle(4);
    chk("mid_queue_empty", 32'(exp_q.size()), 32'h0);

    // Continuous alternating stream of 64 words
    for (int i = 0; i < 64; i++) exp_q.push_back(32'h5000_0000 + 32'(i));
    vcount = 0;
    for (int i = 0; i < 64; i++) begin
      if (i % 2 == 0) cyc(1'b1, 32'h5000_0000 + 32'(i), 1'b0, 32'h0);
      else            cyc(1'b0, 32'h0, 1'b1, 32'h5000_0000 + 32'(i));
      if (i >= 1 && valid_out === 1'b1) vcount++;
    end
    idle(1);
    if (valid_out === 1'b1) vcount++;
    chk("stream_valid_cycles", 32'(vcount), 32'd64);
    idle(3);
    chk("stream_queue_empty", 32'(exp_q.size()), 32'h0);
    chk("stream_overflow", {31'h0, overflow}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_unstriping.md
Name: mux_unstriping

Overview:
- Receive-side counterpart of the transmit-side two-lane stripe (demux_striping).
- Merges the two 32-bit lane streams back into one 32-bit stream at clk_2f, in the original order: lane 0 first, then alternating lanes.
- Each lane has a small FIFO to absorb lane-to-lane skew.
- Sits after the per-lane receive path and before the byte-unstriping/link layer.

Parameters:
- WIDTH, 32, data width of each lane word and of the output word.
- DEPTH, 4, entries per lane FIFO; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk_2f  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- lane_0  input  WIDTH  lane 0 word; sampled when valid_in0=1.
- valid_in0  input  1  lane 0 write strobe; one word per high cycle.
- lane_1  input  WIDTH  lane 1 word; sampled when valid_in1=1.
- valid_in1  input  1  lane 1 write strobe; one word per high cycle.
- data_out  output  WIDTH  merged output word, registered.
- valid_out  output  1  data_out holds a new word this cycle.
- overflow  output  1  sticky: a lane word was dropped because its FIFO was full.
- fill0  output  PTR_W+1  current lane 0 FIFO occupancy (0..DEPTH).
- fill1  output  PTR_W+1  current lane 1 FIFO occupancy (0..DEPTH).

Behaviour:
- Reset (edge with reset=1):
  - data_out=0, valid_out=0, overflow=0.
  - fill0=fill1=0; all read/write pointers=0; sel=0 (lane 0).
  - reset overrides every other input that edge; words strobed that cycle are discarded.
  - reset mid-stream flushes both FIFOs; the next output comes from lane 0.
- Write, per lane, at each edge:
  - valid_inX=1 and FIFO not full (occupancy before the edge < DEPTH): store laneX at wr_ptr, wr_ptr+1 mod DEPTH.
  - valid_inX=1 and FIFO full with no pop of that lane this edge: word dropped, overflow<=1 (stays 1 until reset).
  - full with a pop of the same lane on the same edge: write accepted, occupancy stays DEPTH.
- Read/merge: one state bit, sel, with states LANE0 and LANE1.
  - At each edge, if FIFO[sel] occupancy before the edge > 0: data_out<=FIFO[sel][rd_ptr], valid_out<=1, rd_ptr+1 mod DEPTH, sel toggles.
  - Otherwise: valid_out<=0, data_out holds its last value, sel unchanged.
  - The block never skips a lane: an empty selected lane stalls output even if the other lane has data. This preserves order.
- Latency:
  - a word strobed on edge k is readable from edge k+1 at the earliest, so it appears on data_out/valid_out after edge k+1.
  - no write-to-read bypass.
  - steady state with both lanes fed alternately: one output word per clk_2f cycle.
- Occupancy:
  - push only: +1; pop only: -1; push and pop on the same lane, same edge: unchanged.
  - pointers wrap modulo DEPTH; fillX is registered, updated on the same edge as the pointers.
- Simultaneous strobes on both lanes are legal; both lanes are written independently.
- The output has no backpressure: the downstream block always accepts valid_out.

Test Plan:
- Reset, then lane_0 strobes 0xAAAA0001 at edge 1 and lane_1 strobes 0xBBBB0001 at edge 2 -> valid_out=1 with data_out=0xAAAA0001 after edge 2, then 0xBBBB0001 after edge 3; valid_out=0 after edge 4.
- Skew: lane_1 sends 0xB1, 0xB2 three cycles before lane_0 sends 0xA1, 0xA2 -> no output until 0xA1 is stored; output order is A1, B1, A2, B2 on consecutive cycles; fill1 peaks at 2.
- Overflow: 5 lane_1 strobes with lane 0 idle (DEPTH=4) -> fill1=4, 5th word dropped, overflow=1 and stays 1; then lane_0 sends 4 words -> output alternates A/B for 8 cycles with the first 4 lane_1 words only.
- Full plus pop on the same edge: lane_0 FIFO full and sel=0, lane_0 strobes 0xA5 -> accepted, fill0 stays 4, overflow=0.
- Reset mid-stream: fill0=2, fill1=1, reset high one cycle -> next edge all outputs 0; new pair 0x11/0x22 outputs 0x11 then 0x22.
- Continuous stream of 64 alternating words mirroring demux_striping output -> data_out equals the original sequence exactly; valid_out high every cycle after 2-cycle fill.
